// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: operation request side and result side.
// Requester drives operands/tag and in_valid; adder answers with in_ready.
// Adder drives result/flags/tag_out and out_valid; consumer answers with out_ready.
interface pipe_adder_if #(
   parameter int DATAWIDTH = 32,
   parameter int TAGWIDTH  = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [DATAWIDTH-1:0] a;
   logic [DATAWIDTH-1:0] b;
   logic [1:0]           op;
   logic                 cin;
   logic [TAGWIDTH-1:0]  tag_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATAWIDTH-1:0] sum;
   logic                 carry;
   logic                 overflow;
   logic                 zero;
   logic                 negative;
   logic [TAGWIDTH-1:0]  tag_out;

   modport master (
      output in_valid, a, b, op, cin, tag_in, out_ready,
      input  in_ready, out_valid, sum, carry, overflow, zero, negative, tag_out
   );

   modport slave (
      input  in_valid, a, b, op, cin, tag_in, out_ready,
      output in_ready, out_valid, sum, carry, overflow, zero, negative, tag_out
   );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/sub (carry-select free ripple over STAGES slices of W bits) with tag.
// Latency STAGES cycles, one op per cycle; flags registered with the last slice.
// Backpressure: stages load when empty or advancing; bubbles collapse; in_ready = stage-0 load.
module pipe_adder #(
   parameter int DATAWIDTH = 32,
   parameter int STAGES    = 4,
   parameter int TAGWIDTH  = 4
) (
   input logic        clk,
   input logic        rst,
   pipe_adder_if.slave bus
);
   localparam int W   = DATAWIDTH / STAGES;
   localparam int MSB = DATAWIDTH - 1;
   localparam int L   = STAGES - 1;

   // Stage registers: stage k holds an op whose slices 0..k are summed.
   // a_q/b_q keep the full operands (b already inverted for subtract) so the
   // remaining upper slices and the MSBs needed for overflow travel along.
   logic [STAGES-1:0]    vld_q;
   logic [STAGES-1:0]    c_q;
   logic [DATAWIDTH-1:0] a_q   [STAGES];
   logic [DATAWIDTH-1:0] b_q   [STAGES];
   logic [DATAWIDTH-1:0] s_q   [STAGES];
   logic [TAGWIDTH-1:0]  tag_q [STAGES];
   logic                 ovf_q;
   logic                 zero_q;
   logic                 neg_q;

   logic [STAGES-1:0]    load;
   logic                 take;

   // Stage inputs (from the request port for stage 0, else from the previous stage).
   logic [DATAWIDTH-1:0] a_src   [STAGES];
   logic [DATAWIDTH-1:0] b_src   [STAGES];
   logic [DATAWIDTH-1:0] s_src   [STAGES];
   logic [DATAWIDTH-1:0] s_nxt   [STAGES];
   logic [TAGWIDTH-1:0]  tag_src [STAGES];
   logic [STAGES-1:0]    c_src;
   logic [STAGES-1:0]    c_nxt;
   logic [STAGES-1:0]    v_src;
   logic [W:0]           slice;
   logic                 ovf_nxt;
   logic                 zero_nxt;
   logic                 neg_nxt;

   // Load chain: a stage may load if it is empty or its occupant moves on this cycle.
   always_comb begin
      load    = '0;
      load[L] = !vld_q[L] || bus.out_ready;
      for (int k = L - 1; k >= 0; k--) begin
         load[k] = !vld_q[k] || load[k + 1];
      end
   end

   // Nothing is accepted while reset is held.
   assign bus.in_ready = load[0] && !rst;
   assign take         = bus.in_valid && bus.in_ready;

   // Per-stage slice adders, each only W+1 bits wide.
   always_comb begin
      slice      = '0;
      c_src      = '0;
      c_nxt      = '0;
      v_src      = '0;
      a_src[0]   = bus.a;
      b_src[0]   = bus.b ^ {DATAWIDTH{bus.op[0]}};
      s_src[0]   = '0;
      tag_src[0] = bus.tag_in;
      c_src[0]   = bus.op[1] ? bus.cin : bus.op[0];
      v_src[0]   = take;
      for (int k = 1; k < STAGES; k++) begin
         a_src[k]   = a_q[k - 1];
         b_src[k]   = b_q[k - 1];
         s_src[k]   = s_q[k - 1];
         tag_src[k] = tag_q[k - 1];
         c_src[k]   = c_q[k - 1];
         v_src[k]   = vld_q[k - 1];
      end
      for (int k = 0; k < STAGES; k++) begin
         slice = {1'b0, a_src[k][k*W +: W]} + {1'b0, b_src[k][k*W +: W]} + {{W{1'b0}}, c_src[k]};
         s_nxt[k]          = s_src[k];
         s_nxt[k][k*W +: W] = slice[W-1:0];
         c_nxt[k]          = slice[W];
      end
   end

   // Flags derived from the completed sum, captured alongside the final slice.
   always_comb begin
      ovf_nxt  = (a_src[L][MSB] == b_src[L][MSB]) && (s_nxt[L][MSB] != a_src[L][MSB]);
      zero_nxt = (s_nxt[L] == '0);
      neg_nxt  = s_nxt[L][MSB];
   end

   // Stage state: valid bits follow the load chain; payload only moves with a real op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         c_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            s_q[k]   <= '0;
            tag_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               vld_q[k] <= v_src[k];
               if (v_src[k]) begin
                  a_q[k]   <= a_src[k];
                  b_q[k]   <= b_src[k];
                  s_q[k]   <= s_nxt[k];
                  c_q[k]   <= c_nxt[k];
                  tag_q[k] <= tag_src[k];
               end
            end
         end
         if (load[L] && v_src[L]) begin
            ovf_q  <= ovf_nxt;
            zero_q <= zero_nxt;
            neg_q  <= neg_nxt;
         end
      end
   end

   assign bus.out_valid = vld_q[L];
   assign bus.sum       = s_q[L];
   assign bus.carry     = c_q[L];
   assign bus.overflow  = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.negative  = neg_q;
   assign bus.tag_out   = tag_q[L];
endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder (32-bit, 4 stages): arithmetic reference model with an
// in-order expectation queue, checked every cycle, plus literal directed vectors.
module tb_pipe_adder;
   localparam int DW = 32;
   localparam int ST = 4;
   localparam int TW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_adder_if #(.DATAWIDTH(DW), .TAGWIDTH(TW)) bus ();
   pipe_adder #(.DATAWIDTH(DW), .STAGES(ST), .TAGWIDTH(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] sum;
      logic        carry;
      logic        ovf;
      logic        zero;
      logic        neg;
      logic [3:0]  tag;
   } res_t;

   res_t q[$];
   res_t held;
   bit   hold_prev = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   retired = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain unsigned arithmetic for sum/carry, signed integer range for overflow.
   function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic [3:0] tag);
      logic [32:0] full;
      longint      sa, sb, sr;
      res_t        r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin full = {1'b0, a} + {1'b0, b}; sr = sa + sb; end
         2'b01: begin full = {1'b0, a} + 33'h1_0000_0000 - {1'b0, b}; sr = sa - sb; end
         2'b10: begin full = {1'b0, a} + {1'b0, b} + {32'd0, cin}; sr = sa + sb + (cin ? 64'sd1 : 64'sd0); end
         default: begin full = {1'b0, a} + 33'h1_0000_0000 - {1'b0, b} - {32'd0, !cin};
                        sr = sa - sb - (cin ? 64'sd0 : 64'sd1); end
      endcase
      r.sum   = full[31:0];
      r.carry = full[32];
      r.ovf   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      r.zero  = (full[31:0] == 32'd0);
      r.neg   = full[31];
      r.tag   = tag;
      return r;
   endfunction

   // Per-cycle checker: in_ready vs occupancy, stall stability, in-order results.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         hold_prev = 1'b0;
         chk("in_ready_during_reset", bus.in_ready, 0);
      end else begin
         chk("in_ready", bus.in_ready, !(q.size() == ST && !bus.out_ready));
         if (hold_prev) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_sum", bus.sum, held.sum);
            chk("stall_flags", {bus.carry, bus.overflow, bus.zero, bus.negative},
                {held.carry, held.ovf, held.zero, held.neg});
            chk("stall_tag", bus.tag_out, held.tag);
         end
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", bus.out_valid, 0);
            end else begin
               chk("sum", bus.sum, q[0].sum);
               chk("flags", {bus.carry, bus.overflow, bus.zero, bus.negative},
                   {q[0].carry, q[0].ovf, q[0].zero, q[0].neg});
               chk("tag_order", bus.tag_out, q[0].tag);
               if (bus.out_ready) begin
                  void'(q.pop_front());
                  retired++;
               end
            end
         end
         hold_prev  = bus.out_valid && !bus.out_ready;
         held.sum   = bus.sum;
         held.carry = bus.carry;
         held.ovf   = bus.overflow;
         held.zero  = bus.zero;
         held.neg   = bus.negative;
         held.tag   = bus.tag_out;
         if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.op, bus.a, bus.b, bus.cin, bus.tag_in));
      end
   end

   task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [3:0] tag);
      bus.op     = op;
      bus.a      = a;
      bus.b      = b;
      bus.cin    = cin;
      bus.tag_in = tag;
   endtask

   // One op with the output always ready; result visible STAGES-1 edges after the
   // accepting edge and consumed on the STAGES-th.
   task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cin, input logic [3:0] tag,
                          input logic [31:0] es, input logic [3:0] ef);
      int  n;
      bit  acc;
      @(posedge clk); #1;
      drive(op, a, b, cin, tag);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk); acc = bus.in_ready;
         @(posedge clk); #1; n++;
      end while (!acc && n < 20);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk({name, "_latency"}, n, ST - 1);
      chk({name, "_sum"}, bus.sum, es);
      chk({name, "_flags_cvzn"}, {bus.carry, bus.overflow, bus.zero, bus.negative}, ef);
      chk({name, "_tag"}, bus.tag_out, tag);
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive(2'b00, 32'd0, 32'd0, 1'b0, 4'd0);
      #2;
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_sum", bus.sum, 0);
      chk("reset_flags", {bus.carry, bus.overflow, bus.zero, bus.negative}, 0);
      chk("reset_in_ready", bus.in_ready, 0);
      #21 rst = 1'b0;

      // Literal vectors (flags ordered carry, overflow, zero, negative).
      run_one("add_wrap",   2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'h1, 32'h0000_0000, 4'b1010);
      run_one("sub_ovf",    2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 4'h2, 32'h7FFF_FFFF, 4'b1100);
      run_one("sbb_borrow", 2'b11, 32'd5,         32'd5,         1'b0, 4'h3, 32'hFFFF_FFFF, 4'b0001);
      run_one("adc_ovf",    2'b10, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 4'h4, 32'h8000_0000, 4'b0101);
      run_one("sub_zero",   2'b01, 32'd5,         32'd5,         1'b0, 4'h5, 32'h0000_0000, 4'b1010);
      run_one("add_cin_ignored", 2'b00, 32'd1,    32'd2,         1'b1, 4'h6, 32'h0000_0003, 4'b0000);

      // Ten back-to-back ops with a randomly stalling consumer.
      base = retired;
      fork
         begin : producer
            int i = 0;
            int n = 0;
            bit acc;
            while (i < 10 && n < 300) begin
               drive(2'(i % 4), 32'h1357_9BDF * (i + 1), 32'h0F0F_1234 ^ (32'h1111_1111 * i), i[0], 4'(i));
               bus.in_valid = 1'b1;
               @(negedge clk); acc = bus.in_ready;
               @(posedge clk); #1;
               if (acc) i++;
               n++;
            end
            bus.in_valid = 1'b0;
         end
         begin : consumer
            int n = 0;
            while (retired < base + 10 && n < 400) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1; n++;
            end
            bus.out_ready = 1'b1;
         end
      join
      chk("b2b_retired", retired - base, 10);

      // Fill with the output blocked, then accept and retire together for 20 cycles.
      base = retired;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(2'b00, 32'h0001_0000 * i + 32'hFFFF, 32'd1 + i, 1'b0, 4'(i));
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("full_in_ready_low", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(2'(i % 4), 32'hFFFF_0000 + i, 32'h0000_FFFF * i, ~i[1], 4'(i + 4));
         bus.in_valid = 1'b1;
         @(negedge clk);
         chk("flow_in_ready", bus.in_ready, 1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      for (int n = 0; n < 20 && bus.out_valid; n++) begin
         @(posedge clk); #1;
      end
      chk("flow_retired", retired - base, 24);

      // Asynchronous reset with three ops in flight, first one already at the output.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(2'b00, 32'hA5A5_0000 + i, 32'h0000_1111, 1'b0, 4'(9 + i));
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_out_valid", bus.out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_out_valid", bus.out_valid, 0);
      chk("async_reset_sum", bus.sum, 0);
      chk("async_reset_flags", {bus.carry, bus.overflow, bus.zero, bus.negative}, 0);
      chk("async_reset_tag", bus.tag_out, 0);
      chk("async_reset_in_ready", bus.in_ready, 0);
      @(posedge clk); @(posedge clk); #3 rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) @(posedge clk);
      run_one("after_reset", 2'b01, 32'd100, 32'd58, 1'b0, 4'hE, 32'd42, 4'b1000);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; DATAWIDTH % STAGES == 0, STAGES >= 1.
REQ-003 SHALL have parameter TAGWIDTH, default 4, width of opaque tag carried with each operation.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  operation accepted when in_valid && in_ready at a rising edge.
REQ-008 a  input  DATAWIDTH  operand A.
REQ-009 b  input  DATAWIDTH  operand B.
REQ-010 op  input  2  00 add, 01 sub, 10 add-with-carry, 11 sub-with-borrow.
REQ-011 cin  input  1  carry-in, used only by op 10/11.
REQ-012 tag_in  input  TAGWIDTH  tag returned unchanged with the result.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready at a rising edge.
REQ-015 sum  output  DATAWIDTH  result.
REQ-016 carry, overflow, zero, negative  output  1 each  flags.
REQ-017 tag_out  output  TAGWIDTH  tag of current result.

Function
REQ-018 Effective computation SHALL be {carry,sum} = a + (b ^ {DATAWIDTH{op[0]}}) + c0, c0 = op[0] for op 00/01, c0 = cin for op 10/11, all (DATAWIDTH+1)-bit unsigned.
REQ-019 carry SHALL be the raw MSB carry-out (sub: 1 = no borrow).
REQ-020 overflow SHALL be 1 iff a[MSB] equals the effective-B MSB and sum[MSB] differs from a[MSB].
REQ-021 zero SHALL be 1 iff sum == 0; negative SHALL equal sum[MSB].
REQ-022 Stage k (0..STAGES-1) SHALL add slice bits [(k+1)*W-1 : k*W], W = DATAWIDTH/STAGES, using the carry registered from stage k-1 (stage 0 uses c0); no adder wider than W+1 bits in any stage.
REQ-023 Unprocessed upper operand slices and finished lower sum slices SHALL be carried forward in stage registers alongside tag and op-derived bits.
REQ-024 Each stage SHALL hold a valid bit; a stage loads when it is empty or its contents advance in the same cycle; last stage advances only on out_ready.
REQ-025 in_ready SHALL equal the load condition of stage 0 (combinational from out_ready through the valid chain).
REQ-026 Latency SHALL be exactly STAGES cycles: accepted at edge T, out_valid high after edge T+STAGES-1 when no stall; throughput one operation per cycle.
REQ-027 With out_ready low, results SHALL hold stable (sum, flags, tag_out unchanged) and bubbles SHALL collapse until all stages full, then in_ready = 0.
REQ-028 Simultaneous accept and retire on a full pipeline SHALL proceed with no lost or duplicated operation.
REQ-029 Results SHALL emerge in acceptance order.
REQ-030 Flags SHALL be registered with the final slice; no flag output depends combinationally on a, b, op.

Reset
REQ-031 On rst high, all stage valid bits, out_valid, sum, flags and tag_out SHALL be 0 immediately, regardless of clk.
REQ-032 Reset mid-operation SHALL discard all in-flight operations; none appear after release.
REQ-033 During reset in_ready SHALL be 0; first acceptance possible at first rising edge after rst low.

Verification (DATAWIDTH=32, STAGES=4)
REQ-034 add 0xFFFFFFFF + 0x00000001, out_ready=1 -> after 4 cycles sum=0, carry=1, zero=1, overflow=0; carry crosses all slices.
REQ-035 sub 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, carry=1, overflow=1, negative=0.
REQ-036 op 11 with a=5, b=5, cin=0 -> sum=0xFFFFFFFF, carry=0, negative=1; op 10 with 0x7FFFFFFF+0+cin=1 -> sum=0x80000000, overflow=1.
REQ-037 back-to-back 10 ops, tags 0..9, out_ready toggled random -> all 10 results in tag order, correct values, stable while stalled, in_ready low only when 4 held.
REQ-038 out_ready=0, fill 4 ops, then accept+retire same cycle for 20 cycles -> no loss, no duplicates, in_ready=1 throughout.
REQ-039 rst asserted asynchronously with 3 ops in flight -> out_valid=0 at once, no results emerge after release, next op returns after exactly 4 cycles.
